// File: rtl/gpu_mem_pkg.sv
// Shared GPU memory-port definitions: command sizes, VRAM geometry and the
// VRAM-to-CPU copy engine state encoding.
package gpu_mem_pkg;

  localparam logic [1:0] GPU_CMDSZ_8_BYTE  = 2'd0;
  localparam logic [1:0] GPU_CMDSZ_32_BYTE = 2'd1;
  localparam logic [1:0] GPU_CMDSZ_4_BYTE  = 2'd2;

  localparam int unsigned PIXEL_BURST = 16;
  localparam int unsigned VRAM_W      = 1024;
  localparam int unsigned VRAM_H      = 512;

  localparam int unsigned XW     = $clog2(VRAM_W);
  localparam int unsigned YW     = $clog2(VRAM_H);
  localparam int unsigned LINE_W = PIXEL_BURST * 16;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdReq   = 3'd1;
  localparam logic [2:0] StRdWait  = 3'd2;
  localparam logic [2:0] StExtract = 3'd3;
  localparam logic [2:0] StFlush   = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  function automatic logic [15:0] line_pixel(input logic [LINE_W-1:0] line,
                                             input logic [3:0]        idx);
    return line[{idx, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/gpu_mem_vramcpu_pack.sv
// Packs a 16-bit pixel stream into 32-bit words {p1, p0} behind a
// valid/accept output register; flush emits an odd trailing pixel.
module gpu_mem_vramcpu_pack (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [15:0] pixel_i,
  output logic        push_ready_o,
  input  logic        flush_i,
  output logic        empty_o,
  output logic        data_valid_o,
  output logic [31:0] data_out_o,
  input  logic        data_accept_i
);

  logic        half_q, half_d;
  logic [15:0] p0_q, p0_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  logic        slot_free;

  // The output register can take a new word if empty or being drained now.
  assign slot_free    = !valid_q || data_accept_i;
  assign push_ready_o = !half_q || slot_free;
  assign empty_o      = !half_q && !valid_q;
  assign data_valid_o = valid_q;
  assign data_out_o   = word_q;

  always_comb begin
    half_d  = half_q;
    p0_d    = p0_q;
    valid_d = valid_q && !data_accept_i;
    word_d  = word_q;
    if (push_i && push_ready_o) begin
      if (half_q) begin
        word_d  = {pixel_i, p0_q};
        valid_d = 1'b1;
        half_d  = 1'b0;
      end else begin
        p0_d   = pixel_i;
        half_d = 1'b1;
      end
    end else if (flush_i && half_q && slot_free) begin
      word_d  = {16'h0000, p0_q};
      valid_d = 1'b1;
      half_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      half_q  <= 1'b0;
      p0_q    <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      half_q  <= half_d;
      p0_q    <= p0_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/gpu_mem_vramcpu.sv
// VRAM-to-CPU copy engine: walks a rectangle line by line, issues 32-byte
// reads, and streams the in-rectangle pixels out as packed 32-bit words.
module gpu_mem_vramcpu
  import gpu_mem_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  input  logic [15:0]  req_x_i,
  input  logic [15:0]  req_y_i,
  input  logic [15:0]  req_sizex_i,
  input  logic [15:0]  req_sizey_i,
  output logic         req_accept_o,
  output logic         data_valid_o,
  output logic [31:0]  data_out_o,
  input  logic         data_accept_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         gpu_command_o,
  input  logic         gpu_busy_i,
  output logic [1:0]   gpu_size_o,
  output logic         gpu_write_o,
  output logic [14:0]  gpu_addr_o,
  output logic [2:0]   gpu_sub_addr_o,
  output logic [15:0]  gpu_write_mask_o,
  output logic [255:0] gpu_data_out_o,
  input  logic         gpu_data_in_valid_i,
  input  logic [255:0] gpu_data_in_i
);

  logic [2:0]        state_q, state_d;
  logic [XW-1:0]     cur_x_q, cur_x_d;
  logic [XW-1:0]     start_x_q, start_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d;
  logic [15:0]       sizex_q, sizex_d;
  logic [15:0]       x_remain_q, x_remain_d;
  logic [15:0]       y_remain_q, y_remain_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              rdy_q;
  logic              done_q;

  logic              push;
  logic              push_ready;
  logic              flush;
  logic              pack_empty;
  logic [15:0]       pixel;
  logic              unused_req_bits;

  assign unused_req_bits = ^{req_x_i[15:XW], req_y_i[15:YW]};
  assign pixel           = line_pixel(line_q, cur_x_q[3:0]);

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    start_x_d  = start_x_q;
    cur_y_d    = cur_y_q;
    sizex_d    = sizex_q;
    x_remain_d = x_remain_q;
    y_remain_d = y_remain_q;
    line_d     = line_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && rdy_q) begin
          cur_x_d    = req_x_i[XW-1:0];
          start_x_d  = req_x_i[XW-1:0];
          cur_y_d    = req_y_i[YW-1:0];
          sizex_d    = req_sizex_i;
          x_remain_d = req_sizex_i;
          y_remain_d = req_sizey_i;
          if (req_sizex_i == 16'd0 || req_sizey_i == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (!gpu_busy_i) state_d = StRdWait;
      end
      StRdWait: begin
        if (gpu_data_in_valid_i) begin
          line_d  = gpu_data_in_i;
          state_d = StExtract;
        end
      end
      StExtract: begin
        push = 1'b1;
        if (push_ready) begin
          cur_x_d    = cur_x_q + XW'(1);
          x_remain_d = x_remain_q - 16'd1;
          if (x_remain_q == 16'd1) begin
            // Row end: rewind to the left edge of the rectangle on the next row.
            cur_x_d    = start_x_q;
            x_remain_d = sizex_q;
            cur_y_d    = cur_y_q + YW'(1);
            y_remain_d = y_remain_q - 16'd1;
            state_d    = (y_remain_q == 16'd1) ? StFlush : StRdReq;
          end else if (&cur_x_q[3:0]) begin
            state_d = StRdReq;
          end
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (pack_empty) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      cur_x_q    <= '0;
      start_x_q  <= '0;
      cur_y_q    <= '0;
      sizex_q    <= '0;
      x_remain_q <= '0;
      y_remain_q <= '0;
      line_q     <= '0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      start_x_q  <= start_x_d;
      cur_y_q    <= cur_y_d;
      sizex_q    <= sizex_d;
      x_remain_q <= x_remain_d;
      y_remain_q <= y_remain_d;
      line_q     <= line_d;
      rdy_q      <= 1'b1;
      done_q     <= (state_q == StDone);
    end
  end

  gpu_mem_vramcpu_pack u_pack (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .pixel_i       (pixel),
    .push_ready_o  (push_ready),
    .flush_i       (flush),
    .empty_o       (pack_empty),
    .data_valid_o  (data_valid_o),
    .data_out_o    (data_out_o),
    .data_accept_i (data_accept_i)
  );

  // rdy_q keeps req_accept_o low while reset is asserted.
  assign req_accept_o     = rdy_q && (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign gpu_command_o    = (state_q == StRdReq);
  assign gpu_size_o       = GPU_CMDSZ_32_BYTE;
  assign gpu_write_o      = 1'b0;
  assign gpu_addr_o       = {cur_y_q, cur_x_q[XW-1:4]};
  assign gpu_sub_addr_o   = 3'd0;
  assign gpu_write_mask_o = 16'h0000;
  assign gpu_data_out_o   = '0;

endmodule

// File: tb/tb_gpu_mem_vramcpu.sv
// Scoreboard bench for the VRAM-to-CPU copy engine with a simple VRAM
// responder whose pixel k of line a is {a[11:0], k}.
module tb_gpu_mem_vramcpu;
  import gpu_mem_pkg::*;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [15:0]  req_x, req_y, req_sizex, req_sizey;
  logic         req_accept;
  logic         data_valid;
  logic [31:0]  data_out;
  logic         data_accept;
  logic         busy, done;
  logic         gpu_command, gpu_busy;
  logic [1:0]   gpu_size;
  logic         gpu_write;
  logic [14:0]  gpu_addr;
  logic [2:0]   gpu_sub_addr;
  logic [15:0]  gpu_write_mask;
  logic [255:0] gpu_data_out;
  logic         gpu_data_in_valid;
  logic [255:0] gpu_data_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_words[$];
  logic [14:0] exp_addrs[$];

  gpu_mem_vramcpu dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_valid_i         (req_valid),
    .req_x_i             (req_x),
    .req_y_i             (req_y),
    .req_sizex_i         (req_sizex),
    .req_sizey_i         (req_sizey),
    .req_accept_o        (req_accept),
    .data_valid_o        (data_valid),
    .data_out_o          (data_out),
    .data_accept_i       (data_accept),
    .busy_o              (busy),
    .done_o              (done),
    .gpu_command_o       (gpu_command),
    .gpu_busy_i          (gpu_busy),
    .gpu_size_o          (gpu_size),
    .gpu_write_o         (gpu_write),
    .gpu_addr_o          (gpu_addr),
    .gpu_sub_addr_o      (gpu_sub_addr),
    .gpu_write_mask_o    (gpu_write_mask),
    .gpu_data_out_o      (gpu_data_out),
    .gpu_data_in_valid_i (gpu_data_in_valid),
    .gpu_data_in_i       (gpu_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [14:0] a);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) l[16*k +: 16] = {a[11:0], 4'(k)};
    return l;
  endfunction

  // Output word monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && data_valid && data_accept) begin
        if (exp_words.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", data_out);
        end else begin
          e = exp_words.pop_front();
          chk("data_word", data_out, e);
        end
      end
    end
  end

  // Read monitor and VRAM responder: one beat per accepted read, 3 cycles later.
  initial begin
    logic [14:0] a;
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (rst && gpu_command && !gpu_busy) begin
        a = gpu_addr;
        if (exp_addrs.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got %h expected none", a);
        end else begin
          e = exp_addrs.pop_front();
          chk("read_addr", 32'(a), 32'(e));
        end
        chk("read_cmd_consts", {27'd0, gpu_write, gpu_size, gpu_sub_addr[1:0]},
            {27'd0, 1'b0, GPU_CMDSZ_32_BYTE, 2'b00});
        repeat (3) @(posedge clk);
        #1;
        gpu_data_in_valid = 1'b1;
        gpu_data_in       = mk_line(a);
        @(posedge clk);
        #1;
        gpu_data_in_valid = 1'b0;
      end
    end
  end

  task automatic do_req(input int x, input int y, input int sx, input int sy);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_accept) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_x     = 16'(x);
    req_y     = 16'(y);
    req_sizex = 16'(sx);
    req_sizey = 16'(sy);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(done), 32'd0);
    chk({name, "_words_left"}, 32'(exp_words.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(exp_addrs.size()), 32'd0);
  endtask

  initial begin
    logic [14:0] held;
    rst = 1'b0;
    req_valid = 1'b0;
    req_x = '0;
    req_y = '0;
    req_sizex = '0;
    req_sizey = '0;
    data_accept = 1'b1;
    gpu_busy = 1'b0;
    gpu_data_in_valid = 1'b0;
    gpu_data_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_accept", 32'(req_accept), 32'd0);
    chk("rst_outputs", {26'd0, data_valid, busy, done, gpu_command, gpu_write, 1'b0},
        32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_addr", 32'(gpu_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_accept_after_rst", 32'(req_accept), 32'd1);

    // Single aligned line
    exp_addrs.push_back(15'h0000);
    for (int i = 0; i < 8; i++) exp_words.push_back({16'(2*i+1), 16'(2*i)});
    do_req(0, 0, 16, 1);
    chk("cmd_next_cycle", 32'(gpu_command), 32'd1);
    chk("busy_next_cycle", 32'(busy), 32'd1);
    wait_done("t1_done");

    // Unaligned span across two lines
    exp_addrs.push_back(15'h00C0);
    exp_addrs.push_back(15'h00C1);
    exp_words.push_back(32'h0C0F0C0E);
    exp_words.push_back(32'h0C110C10);
    do_req(14, 3, 4, 1);
    wait_done("t2_done");

    // Odd total, pair straddling a row boundary
    exp_addrs.push_back(15'h01C0);
    exp_addrs.push_back(15'h0200);
    exp_addrs.push_back(15'h0240);
    exp_words.push_back(32'h1C061C05);
    exp_words.push_back(32'h20051C07);
    exp_words.push_back(32'h20072006);
    exp_words.push_back(32'h24062405);
    exp_words.push_back(32'h00002407);
    do_req(5, 7, 3, 3);
    wait_done("t3_done");

    // X and Y wrap
    exp_addrs.push_back(15'h7FFF);
    exp_addrs.push_back(15'h7FC0);
    exp_addrs.push_back(15'h003F);
    exp_addrs.push_back(15'h0000);
    exp_words.push_back(32'hFFFDFFFC);
    exp_words.push_back(32'hFFFFFFFE);
    exp_words.push_back(32'hFC01FC00);
    exp_words.push_back(32'hFC03FC02);
    exp_words.push_back(32'h03FD03FC);
    exp_words.push_back(32'h03FF03FE);
    exp_words.push_back(32'h00010000);
    exp_words.push_back(32'h00030002);
    do_req(1020, 511, 8, 2);
    wait_done("t4_done");

    // Backpressure on both sides
    exp_addrs.push_back(15'h0040);
    exp_addrs.push_back(15'h0041);
    for (int i = 0; i < 16; i++) begin
      exp_words.push_back({16'h0400 + 16'(2*i+1), 16'h0400 + 16'(2*i)});
    end
    data_accept = 1'b0;
    gpu_busy = 1'b1;
    do_req(0, 1, 32, 1);
    @(negedge clk);
    held = gpu_addr;
    chk("stall_cmd", 32'(gpu_command), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr_stable", 32'(gpu_addr), 32'(held));
      chk("stall_cmd_held", 32'(gpu_command), 32'd1);
    end
    @(posedge clk);
    #1;
    gpu_busy = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    data_accept = 1'b1;
    wait_done("t5_done");

    // Zero size: immediate completion, no reads
    do_req(3, 3, 0, 4);
    @(negedge clk);
    chk("zero_done_early", 32'(done), 32'd0);
    chk("zero_no_cmd", 32'(gpu_command), 32'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_no_cmd2", 32'(gpu_command), 32'd0);
    @(negedge clk);
    chk("zero_done_pulse", 32'(done), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);

    // Reset in the middle of extraction
    exp_addrs.push_back(15'h0000);
    data_accept = 1'b0;
    do_req(0, 0, 16, 1);
    begin
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (data_valid) begin
          got = 1;
          break;
        end
      end
      chk("mid_first_word", 32'(got), 32'd1);
    end
    chk("mid_word_value", data_out, 32'h00010000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {25'd0, data_valid, busy, done, gpu_command, req_accept, 2'b00},
        32'd0);
    chk("abort_data_out", data_out, 32'd0);
    chk("abort_addr", 32'(gpu_addr), 32'd0);
    exp_words.delete();
    exp_addrs.delete();
    data_accept = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    gpu_data_in_valid = 1'b1;
    gpu_data_in = mk_line(15'h0000);
    @(posedge clk);
    #1;
    gpu_data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_beat_ignored", {29'd0, data_valid, busy, gpu_command}, 32'd0);
    chk("late_beat_idle", 32'(req_accept), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
